// File: rtl/led_pio_pkg.sv
// Shared definitions for the LED output PIO and related blinking peripherals.
// Holds the register word addresses and the default blink prescaler divisor.
package led_pio_pkg;

    // Register word addresses
    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_BLINK    = 2'd1;
    localparam logic [1:0] ADDR_OUTSET   = 2'd2;
    localparam logic [1:0] ADDR_OUTCLEAR = 2'd3;

    // Clocks per blink half-period
    localparam int unsigned BLINK_DIV_DEFAULT = 25000000;

endpackage

// File: rtl/led_out_pio_blink_prescaler.sv
// Blink prescaler: divides clk down to a square wave with BLINK_DIV clocks
// per half-period.
// Ports:
//   clk          system clock
//   reset_n      synchronous active-low reset
//   restart      forces div_cnt=0 and phase=0 on the next edge
//   phase        registered blink phase
//   phase_next_c value phase takes at the next edge, so a consumer can
//                register a phase-gated output in step with phase itself
module blink_prescaler
    import led_pio_pkg::*;
#(
    parameter int unsigned BLINK_DIV = BLINK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic phase,
    output logic phase_next_c
);

    localparam int unsigned CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] cnt_next;

    // Next-state: restart has priority over the terminal-count wrap
    always_comb begin
        cnt_next     = div_cnt + CNT_W'(1);
        phase_next_c = phase;
        if (restart) begin
            cnt_next     = '0;
            phase_next_c = 1'b0;
        end else if (div_cnt == CNT_LAST) begin
            cnt_next     = '0;
            phase_next_c = ~phase;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else begin
            div_cnt <= cnt_next;
            phase   <= phase_next_c;
        end
    end

endmodule

// File: rtl/led_out_pio.sv
// LED output PIO: Avalon-MM slave with a writable data register, atomic
// set/clear aliases and a per-bit blink mask gated by a divided clock.
// Ports:
//   clk, reset_n  clock and synchronous active-low reset
//   address       register word address (DATA, BLINK, OUTSET, OUTCLEAR)
//   chipselect    slave select
//   write_n       active-low write strobe, qualified by chipselect
//   writedata     write data; bits above WIDTH-1 ignored
//   readdata      registered read data, zero-extended, 1-clock latency
//   out_port      registered LED drive
module led_out_pio
    import led_pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int unsigned BLINK_DIV   = BLINK_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] blink_mask;
    logic [WIDTH-1:0] data_next;
    logic [WIDTH-1:0] mask_next;
    logic [WIDTH-1:0] wdata_c;
    logic [31:0]      rd_mux_c;
    logic             wr_c;
    logic             restart_c;
    logic             phase_next_c;
    logic             unused_phase;
    logic             unused_wdata_c;

    assign wr_c           = chipselect & ~write_n;
    assign wdata_c        = writedata[WIDTH-1:0];
    assign unused_wdata_c = ^writedata;

    blink_prescaler #(
        .BLINK_DIV (BLINK_DIV)
    ) u_prescaler (
        .clk          (clk),
        .reset_n      (reset_n),
        .restart      (restart_c),
        .phase        (unused_phase),
        .phase_next_c (phase_next_c)
    );

    // Register write decode
    always_comb begin
        data_next = data;
        mask_next = blink_mask;
        restart_c = 1'b0;
        if (wr_c) begin
            case (address)
                ADDR_DATA:     data_next = wdata_c;
                ADDR_BLINK: begin
                    mask_next = wdata_c;
                    restart_c = 1'b1;
                end
                ADDR_OUTSET:   data_next = data | wdata_c;
                ADDR_OUTCLEAR: data_next = data & ~wdata_c;
                default:       data_next = data;
            endcase
        end
    end

    // Read mux on current (pre-write) register values; alias addresses read 0
    always_comb begin
        rd_mux_c = 32'h0;
        case (address)
            ADDR_DATA:  rd_mux_c = 32'(data);
            ADDR_BLINK: rd_mux_c = 32'(blink_mask);
            default:    rd_mux_c = 32'h0;
        endcase
    end

    // Output uses next-state values so a write is visible right after its edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data       <= RESET_VALUE[WIDTH-1:0];
            blink_mask <= '0;
            readdata   <= 32'h0;
            out_port   <= RESET_VALUE[WIDTH-1:0];
        end else begin
            data       <= data_next;
            blink_mask <= mask_next;
            readdata   <= rd_mux_c;
            out_port   <= data_next & ~(mask_next & {WIDTH{phase_next_c}});
        end
    end

endmodule

// File: tb/tb_led_out_pio.sv
// Directed testbench for led_out_pio (WIDTH=8, BLINK_DIV=4, RESET_VALUE=0).
module tb_led_out_pio;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int errors;
    int checks;

    led_out_pio #(
        .WIDTH       (8),
        .RESET_VALUE (32'h0),
        .BLINK_DIV   (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Single-cycle write; address is left presented afterwards
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_out;
        errors     = 0;
        checks     = 0;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;

        tick(); tick(); tick();
        check("reset_out", 32'(out_port), 32'h0);
        check("reset_rd", readdata, 32'h0);

        // Idle after reset release
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_out", 32'(out_port), 32'h0);
            check("idle_rd", readdata, 32'h0);
        end

        // Reset wins over a simultaneous DATA write
        reset_n = 1'b0;
        bus_write(2'd0, 32'hFF);
        reset_n = 1'b1;
        check("rst_vs_wr_out", 32'(out_port), 32'h0);
        tick();
        check("rst_vs_wr_out2", 32'(out_port), 32'h0);
        check("rst_vs_wr_rd", readdata, 32'h0);

        // DATA write drops bits above WIDTH; read returns old value on write edge
        bus_write(2'd0, 32'h1A5);
        check("data_out", 32'(out_port), 32'hA5);
        check("data_rd_old", readdata, 32'h0);
        tick();
        check("data_rd", readdata, 32'h000000A5);

        // Set / clear aliases
        bus_write(2'd0, 32'h0F);
        check("seq_data", 32'(out_port), 32'h0F);
        bus_write(2'd2, 32'hF0);
        check("seq_set", 32'(out_port), 32'hFF);
        bus_write(2'd3, 32'h3C);
        check("seq_clr", 32'(out_port), 32'hC3);
        address = 2'd2;
        tick();
        check("rd_outset", readdata, 32'h0);
        address = 2'd3;
        tick();
        check("rd_outclr", readdata, 32'h0);
        address = 2'd0;
        tick();
        check("rd_data_c3", readdata, 32'h000000C3);

        // Blink: 4 clocks 0xFF, 4 clocks 0xF0 from the BLINK write edge
        bus_write(2'd0, 32'hFF);
        bus_write(2'd1, 32'h0F);
        check("blink_out_0", 32'(out_port), 32'hFF);
        for (int i = 1; i <= 14; i++) begin
            tick();
            exp_out = (((i / 4) % 2) == 0) ? 8'hFF : 8'hF0;
            check("blink_out", 32'(out_port), 32'(exp_out));
            check("blink_rd", readdata, 32'h0F);
        end

        // Now phase=1, div_cnt=2: rewrite BLINK restarts the divider
        bus_write(2'd1, 32'h0F);
        check("restart_out_0", 32'(out_port), 32'hFF);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("restart_out", 32'(out_port), 32'hFF);
        end
        tick();
        check("restart_out_off", 32'(out_port), 32'hF0);

        // Stop blinking, then back-to-back writes on consecutive edges
        bus_write(2'd1, 32'h0);
        check("unblink_out", 32'(out_port), 32'hFF);
        bus_write(2'd0, 32'h01);
        check("b2b_data", 32'(out_port), 32'h01);
        bus_write(2'd2, 32'h02);
        check("b2b_set", 32'(out_port), 32'h03);
        bus_write(2'd3, 32'h01);
        check("b2b_clr", 32'(out_port), 32'h02);
        address = 2'd0;
        tick();
        check("b2b_rd", readdata, 32'h02);
        address = 2'd1;
        tick();
        check("blink_rd_zero", readdata, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
